bcd_serial_subtractor: RTL and testbench

Multi-digit packed-BCD subtractor that computes minuend − subtrahend one decimal digit per clock, least-significant digit first, using a borrow chain with decimal correction. It is the subtraction counterpart of the team's combinational BCD adder. It sits beside that adder in the arithmetic datapath and is driven by a start/busy/done handshake. The result is delivered in ten's-complement form with a borrow flag, and any non-BCD input digit is rejected.

---
 rtl/bcd_serial_subtractor_if.sv | 36 +++
 rtl/bcd_serial_subtractor.sv | 162 ++++++++++++++++
 tb/tb_bcd_serial_subtractor.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/bcd_serial_subtractor_if.sv
// Handshake and operand/result bundle for the serial BCD subtractor.
// master: the requester driving start and operands; slave: the subtractor.
interface bcd_serial_subtractor_if #(
    parameter int unsigned DIGITS = 4
);
    logic                  start;
    logic [4*DIGITS-1:0]   minuend;
    logic [4*DIGITS-1:0]   subtrahend;
    logic                  busy;
    logic                  done;
    logic [4*DIGITS-1:0]   difference;
    logic                  borrowOut;
    logic                  invalid;

    modport master (
        output start,
        output minuend,
        output subtrahend,
        input  busy,
        input  done,
        input  difference,
        input  borrowOut,
        input  invalid
    );

    modport slave (
        input  start,
        input  minuend,
        input  subtrahend,
        output busy,
        output done,
        output difference,
        output borrowOut,
        output invalid
    );
endinterface

// File: rtl/bcd_serial_subtractor.sv
// Packed-BCD subtractor, one decimal digit per clock, LSD first.
// Result is (10^DIGITS + A - B) mod 10^DIGITS with a borrow flag; any operand
// digit above 9 makes the operation report invalid with a zero result.
module bcd_serial_subtractor #(
    parameter int unsigned DIGITS = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    bcd_serial_subtractor_if.slave  bus
);
    localparam int unsigned W    = 4 * DIGITS;
    localparam int unsigned CntW = $clog2(DIGITS + 1);

    localparam logic [CntW-1:0] CntLast = CntW'(DIGITS - 1);
    // cnt == DIGITS marks the commit cycle between the last digit and FIN.
    localparam logic [CntW-1:0] CntCommit = CntW'(DIGITS);

    typedef enum logic [1:0] {StIdle, StCheck, StRun, StFin} state_e;

    state_e          state_q, state_d;
    logic [W-1:0]    a_q, a_d;
    logic [W-1:0]    b_q, b_d;
    logic [W-1:0]    shadow_q, shadow_d;
    logic            borrow_q, borrow_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            inv_path_q, inv_path_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic [W-1:0]    diff_q, diff_d;
    logic            borrow_out_q, borrow_out_d;
    logic            invalid_q, invalid_d;

    logic [4:0]      digit_diff;
    logic [3:0]      digit_res;

    // True when any digit of either operand is outside 0..9.
    function automatic logic has_bad_digit(input logic [W-1:0] a, input logic [W-1:0] b);
        logic bad;
        bad = 1'b0;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (a[4*i +: 4] > 4'd9 || b[4*i +: 4] > 4'd9) begin
                bad = 1'b1;
            end
        end
        return bad;
    endfunction

    // Digit datapath: operands are shifted right, so the active digit is always at [3:0].
    always_comb begin
        digit_diff = {1'b0, a_q[3:0]} - {1'b0, b_q[3:0]} - {4'b0, borrow_q};
        // Negative result wraps mod 16; adding 10 then gives the decimal digit.
        digit_res  = digit_diff[4] ? (digit_diff[3:0] + 4'd10) : digit_diff[3:0];
    end

    // Next-state and registered-output logic of the control FSM.
    always_comb begin
        state_d      = state_q;
        a_d          = a_q;
        b_d          = b_q;
        shadow_d     = shadow_q;
        borrow_d     = borrow_q;
        cnt_d        = cnt_q;
        inv_path_d   = inv_path_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        diff_d       = diff_q;
        borrow_out_d = borrow_out_q;
        invalid_d    = invalid_q;

        case (state_q)
            StIdle: begin
                if (bus.start) begin
                    a_d        = bus.minuend;
                    b_d        = bus.subtrahend;
                    shadow_d   = '0;
                    borrow_d   = 1'b0;
                    cnt_d      = '0;
                    inv_path_d = 1'b0;
                    busy_d     = 1'b1;
                    state_d    = StCheck;
                end
            end
            StCheck: begin
                state_d = StRun;
                if (has_bad_digit(a_q, b_q)) begin
                    // Skip straight to the commit cycle so FIN lands two cycles after start.
                    inv_path_d = 1'b1;
                    cnt_d      = CntCommit;
                    busy_d     = 1'b0;
                end
            end
            StRun: begin
                if (cnt_q == CntCommit) begin
                    state_d = StFin;
                    done_d  = 1'b1;
                    if (inv_path_q) begin
                        diff_d       = '0;
                        borrow_out_d = 1'b0;
                        invalid_d    = 1'b1;
                    end else begin
                        diff_d       = shadow_q;
                        borrow_out_d = borrow_q;
                        invalid_d    = 1'b0;
                    end
                end else begin
                    // Result digits enter at the top and reach their slot after DIGITS shifts.
                    shadow_d = (shadow_q >> 4) | (W'(digit_res) << (W - 4));
                    a_d      = a_q >> 4;
                    b_d      = b_q >> 4;
                    borrow_d = digit_diff[4];
                    cnt_d    = cnt_q + 1'b1;
                    if (cnt_q == CntLast) begin
                        busy_d = 1'b0;
                    end
                end
            end
            StFin: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and output registers; reset clears results and aborts any operation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            a_q          <= '0;
            b_q          <= '0;
            shadow_q     <= '0;
            borrow_q     <= 1'b0;
            cnt_q        <= '0;
            inv_path_q   <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            diff_q       <= '0;
            borrow_out_q <= 1'b0;
            invalid_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            a_q          <= a_d;
            b_q          <= b_d;
            shadow_q     <= shadow_d;
            borrow_q     <= borrow_d;
            cnt_q        <= cnt_d;
            inv_path_q   <= inv_path_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            diff_q       <= diff_d;
            borrow_out_q <= borrow_out_d;
            invalid_q    <= invalid_d;
        end
    end

    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.difference = diff_q;
    assign bus.borrowOut  = borrow_out_q;
    assign bus.invalid    = invalid_q;
endmodule

// File: tb/tb_bcd_serial_subtractor.sv
// Self-checking bench for bcd_serial_subtractor (DIGITS=4): vector table plus
// hand-written corner sequences; results checked through a scoreboard queue.
module tb_bcd_serial_subtractor;
    localparam int unsigned DIGITS = 4;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] diff;
        logic        bo;
        logic        inv;
        int          lat;
        int          busy_cyc;
    } vec_t;

    typedef struct {
        logic [15:0] diff;
        logic        bo;
        logic        inv;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    exp_t sb[$];
    exp_t mon_e;
    vec_t vecs[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    always #5 clk = ~clk;

    bcd_serial_subtractor_if #(.DIGITS(DIGITS)) bus ();

    bcd_serial_subtractor #(.DIGITS(DIGITS)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, want %0h", name, act, exp);
    endtask

    function automatic int bcd2int(input logic [15:0] v);
        int r = 0;
        for (int i = 3; i >= 0; i--) r = r * 10 + int'(v[4*i +: 4]);
        return r;
    endfunction

    function automatic logic [15:0] int2bcd(input int n);
        logic [15:0] r;
        int          m = n;
        for (int i = 0; i < 4; i++) begin
            r[4*i +: 4] = 4'(m % 10);
            m = m / 10;
        end
        return r;
    endfunction

    function automatic logic [15:0] rand_bcd();
        logic [15:0] r;
        for (int i = 0; i < 4; i++) r[4*i +: 4] = 4'($urandom_range(9));
        return r;
    endfunction

    function automatic vec_t mk(input logic [15:0] a, input logic [15:0] b,
                                input logic [15:0] d, input logic bo, input logic inv);
        vec_t v;
        v.a = a; v.b = b; v.diff = d; v.bo = bo; v.inv = inv;
        v.lat      = inv ? 2 : 6;
        v.busy_cyc = inv ? 1 : 5;
        return v;
    endfunction

    // Expected value from plain decimal arithmetic, independent of any digit chain.
    function automatic vec_t mk_model(input logic [15:0] a, input logic [15:0] b);
        int ai = bcd2int(a);
        int bi = bcd2int(b);
        return mk(a, b, int2bcd((10000 + ai - bi) % 10000), ai < bi, 1'b0);
    endfunction

    // Scoreboard: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst_n && bus.done === 1'b1) begin
            chk("busy_low_with_done", 32'(bus.busy), 32'd0);
            chk("done_expected", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                mon_e = sb.pop_front();
                chk("difference", 32'(bus.difference), 32'(mon_e.diff));
                chk("borrowOut", 32'(bus.borrowOut), 32'(mon_e.bo));
                chk("invalid", 32'(bus.invalid), 32'(mon_e.inv));
            end
        end
    end

    // disturb: 0 none, 1 restart with 9999 while busy, 2 start during the done cycle.
    task automatic run_op(input vec_t v, input string name, input int disturb);
        int   lat = 0;
        int   busy_cyc = 0;
        exp_t e;
        @(negedge clk);
        bus.minuend    = v.a;
        bus.subtrahend = v.b;
        bus.start      = 1'b1;
        e.diff = v.diff; e.bo = v.bo; e.inv = v.inv;
        sb.push_back(e);
        @(negedge clk);
        bus.start      = 1'b0;
        bus.minuend    = 16'($urandom);
        bus.subtrahend = 16'($urandom);
        while (bus.done !== 1'b1 && lat < 30) begin
            if (bus.busy === 1'b1) busy_cyc++;
            if (disturb == 1 && lat == 2) begin
                bus.minuend    = 16'h9999;
                bus.subtrahend = 16'h0000;
                bus.start      = 1'b1;
            end else begin
                bus.start = 1'b0;
            end
            @(negedge clk);
            lat++;
        end
        bus.start = 1'b0;
        chk({name, "_latency"}, 32'(lat), 32'(v.lat));
        chk({name, "_busy_cycles"}, 32'(busy_cyc), 32'(v.busy_cyc));
        if (lat >= 30) sb.delete();
        if (disturb == 2) begin
            bus.minuend    = 16'h0001;
            bus.subtrahend = 16'h0000;
            bus.start      = 1'b1;
            @(negedge clk);
            bus.start = 1'b0;
            chk({name, "_start_in_done_ignored"}, 32'(bus.busy), 32'd0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.start      = 1'b0;
        bus.minuend    = '0;
        bus.subtrahend = '0;

        vecs.push_back(mk(16'h5432, 16'h1234, 16'h4198, 1'b0, 1'b0));
        vecs.push_back(mk(16'h1000, 16'h0001, 16'h0999, 1'b0, 1'b0));
        vecs.push_back(mk(16'h0000, 16'h0001, 16'h9999, 1'b1, 1'b0));
        vecs.push_back(mk(16'h0025, 16'h0025, 16'h0000, 1'b0, 1'b0));
        vecs.push_back(mk(16'h12A4, 16'h0001, 16'h0000, 1'b0, 1'b1));
        vecs.push_back(mk(16'h0500, 16'h0300, 16'h0200, 1'b0, 1'b0));
        vecs.push_back(mk(16'h1234, 16'h5432, 16'h5802, 1'b1, 1'b0));
        vecs.push_back(mk(16'h0100, 16'h00F0, 16'h0000, 1'b0, 1'b1));
        vecs.push_back(mk(16'h9999, 16'h0000, 16'h9999, 1'b0, 1'b0));
        for (int i = 0; i < 4; i++) vecs.push_back(mk_model(rand_bcd(), rand_bcd()));

        // Reset state
        #2 rst_n = 1'b0;
        #1;
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_difference", 32'(bus.difference), 32'd0);
        chk("rst_borrowOut", 32'(bus.borrowOut), 32'd0);
        chk("rst_invalid", 32'(bus.invalid), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) run_op(vecs[i], $sformatf("vec%0d", i), 0);

        // Restart while busy is ignored; start during done cycle is ignored.
        run_op(mk(16'h0010, 16'h0001, 16'h0009, 1'b0, 1'b0), "restart_busy", 1);
        run_op(mk(16'h0010, 16'h0001, 16'h0009, 1'b0, 1'b0), "start_in_done", 2);
        repeat (8) @(negedge clk);

        // Reset during RUN aborts: no expectation pushed, so any done would be flagged.
        @(negedge clk);
        bus.minuend    = 16'h9999;
        bus.subtrahend = 16'h0001;
        bus.start      = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        chk("abort_busy_before_reset", 32'(bus.busy), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("abort_busy", 32'(bus.busy), 32'd0);
        chk("abort_done", 32'(bus.done), 32'd0);
        chk("abort_difference", 32'(bus.difference), 32'd0);
        chk("abort_borrowOut", 32'(bus.borrowOut), 32'd0);
        chk("abort_invalid", 32'(bus.invalid), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        run_op(mk(16'h9999, 16'h0001, 16'h9998, 1'b0, 1'b0), "after_reset", 0);
        repeat (3) @(negedge clk);
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
